wb_arbiter: RTL and testbench

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_pkg.sv | 14 +
 rtl/wb_fifo.sv | 58 +++++
 rtl/wb_arbiter.sv | 120 ++++++++++++
 tb/tb_wb_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared definitions for the register-file write arbiter: register select width,
// default geometry and the queue entry layout.
package wb_pkg;

    localparam int REG_BITS  = 3;
    localparam int DEF_WIDTH = 16;
    localparam int DEF_DEPTH = 4;

    typedef struct packed {
        logic [REG_BITS-1:0]  regsel;
        logic [DEF_WIDTH-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// In-order write queue with two push ports (push0 lands ahead of push1), one pop
// port, and an oldest-first view of every slot for the hazard/bypass search.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int  DEPTH   = DEF_DEPTH,
    parameter type entry_t = wb_entry_t,
    localparam int PW      = $clog2(DEPTH)
)(
    input  logic               clk,
    input  logic               rst,
    input  logic               push0,
    input  entry_t             din0,
    input  logic               push1,
    input  entry_t             din1,
    input  logic               pop,
    output entry_t             head,
    output logic [PW:0]        count,
    output entry_t [DEPTH-1:0] view,
    output logic [DEPTH-1:0]   view_vld
);

    entry_t        mem [DEPTH];
    logic [PW-1:0] rptr;
    logic [PW-1:0] wptr;
    logic [PW-1:0] wptr1;
    logic [1:0]    npush;

    assign npush = {1'b0, push0} + {1'b0, push1};
    // push1 takes the slot after push0 when both arrive together
    assign wptr1 = push0 ? wptr + PW'(1) : wptr;
    assign head  = mem[rptr];

    always_ff @(posedge clk) begin
        if (push0) mem[wptr]  <= din0;
        if (push1) mem[wptr1] <= din1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else begin
            rptr  <= rptr + PW'(pop);
            wptr  <= wptr + PW'(npush);
            count <= count + (PW+1)'(npush) - (PW+1)'(pop);
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            view[i]     = mem[rptr + PW'(i)];
            view_vld[i] = (PW+1)'(i) < count;
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Merges ALU and load results into a single registered register-file write port
// through an in-order queue, with a youngest-wins bypass query and WAW detection.
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
)(
    input  logic                clk,
    input  logic                rst,
    input  logic                alu_valid,
    input  logic [REG_BITS-1:0] alu_regsel,
    input  logic [WIDTH-1:0]    alu_data,
    output logic                alu_ready,
    input  logic                mem_valid,
    input  logic [REG_BITS-1:0] mem_regsel,
    input  logic [WIDTH-1:0]    mem_data,
    output logic                mem_ready,
    output logic                write,
    output logic [REG_BITS-1:0] writeregsel,
    output logic [WIDTH-1:0]    writedata,
    input  logic [REG_BITS-1:0] q_regsel,
    output logic                q_hit,
    output logic [WIDTH-1:0]    q_data,
    output logic                busy,
    output logic                err
);

    localparam int PW = $clog2(DEPTH);

    typedef struct packed {
        logic [REG_BITS-1:0] regsel;
        logic [WIDTH-1:0]    data;
    } entry_t;

    entry_t             head;
    entry_t             mem_ent;
    entry_t             alu_ent;
    entry_t [DEPTH-1:0] view;
    logic [DEPTH-1:0]   view_vld;
    logic [PW:0]        count;
    logic [PW:0]        free_after;
    logic               pop;
    logic               mem_ok;
    logic               alu_ok;
    logic               mem_push;
    logic               alu_push;
    logic               hit;
    logic [WIDTH-1:0]   hit_data;

    assign mem_ent = '{regsel: mem_regsel, data: mem_data};
    assign alu_ent = '{regsel: alu_regsel, data: alu_data};

    // Slots available once this cycle's head has left; the load result claims first.
    assign pop        = (count != '0);
    assign free_after = (PW+1)'(DEPTH) - count + (PW+1)'(pop);
    assign mem_ok     = (free_after != '0);
    assign alu_ok     = ((free_after - (PW+1)'(mem_valid & mem_ok)) != '0);

    assign mem_ready = ~rst | mem_ok;
    assign alu_ready = ~rst | alu_ok;
    assign mem_push  = rst & mem_valid & mem_ok;
    assign alu_push  = rst & alu_valid & alu_ok;

    wb_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push0    (mem_push),
        .din0     (mem_ent),
        .push1    (alu_push),
        .din1     (alu_ent),
        .pop      (pop),
        .head     (head),
        .count    (count),
        .view     (view),
        .view_vld (view_vld)
    );

    // Output register stage: drives the register file one cycle after dequeue
    always_ff @(posedge clk) begin
        if (!rst) begin
            write       <= 1'b0;
            writeregsel <= '0;
            writedata   <= '0;
        end else begin
            write <= pop;
            if (pop) begin
                writeregsel <= head.regsel;
                writedata   <= head.data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst)
            err <= 1'b0;
        else if (mem_push && alu_push && (mem_regsel == alu_regsel))
            err <= 1'b1;
    end

    // Scan oldest to youngest so the last match is the youngest writer.
    always_comb begin
        hit      = write && (writeregsel == q_regsel);
        hit_data = hit ? writedata : '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (view_vld[i] && (view[i].regsel == q_regsel)) begin
                hit      = 1'b1;
                hit_data = view[i].data;
            end
        end
    end

    assign q_hit  = rst & hit;
    assign q_data = q_hit ? hit_data : '0;
    assign busy   = rst & (pop | write);

endmodule

// File: tb/tb_wb_arbiter.sv
// Scenario bench for wb_arbiter: directed cases plus randomized traffic checked
// against a queue-based reference of the accept/dequeue/query rules.
module tb_wb_arbiter;

    localparam int WIDTH = 16;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [2:0]  r;
        logic [15:0] d;
    } ent_t;

    logic        clk;
    logic        rst;
    logic        alu_valid;
    logic [2:0]  alu_regsel;
    logic [15:0] alu_data;
    logic        alu_ready;
    logic        mem_valid;
    logic [2:0]  mem_regsel;
    logic [15:0] mem_data;
    logic        mem_ready;
    logic        write;
    logic [2:0]  writeregsel;
    logic [15:0] writedata;
    logic [2:0]  q_regsel;
    logic        q_hit;
    logic [15:0] q_data;
    logic        busy;
    logic        err;

    int n_checks = 0;
    int n_pass   = 0;

    ent_t        mq[$];
    bit          m_write;
    logic [2:0]  m_wsel;
    logic [15:0] m_wdata;
    bit          m_err;
    bit          last_mh;
    bit          last_ah;
    ent_t        wlog[$];
    logic [15:0] rf [8];

    wb_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .alu_valid   (alu_valid),
        .alu_regsel  (alu_regsel),
        .alu_data    (alu_data),
        .alu_ready   (alu_ready),
        .mem_valid   (mem_valid),
        .mem_regsel  (mem_regsel),
        .mem_data    (mem_data),
        .mem_ready   (mem_ready),
        .write       (write),
        .writeregsel (writeregsel),
        .writedata   (writedata),
        .q_regsel    (q_regsel),
        .q_hit       (q_hit),
        .q_data      (q_data),
        .busy        (busy),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    // Reference: free slots after this cycle's dequeue; load claims a slot before ALU.
    function automatic bit m_mem_rdy();
        int free;
        if (!rst) return 1'b1;
        free = DEPTH - mq.size() + ((mq.size() > 0) ? 1 : 0);
        return free >= 1;
    endfunction

    function automatic bit m_alu_rdy();
        int free;
        if (!rst) return 1'b1;
        free = DEPTH - mq.size() + ((mq.size() > 0) ? 1 : 0) - ((mem_valid && m_mem_rdy()) ? 1 : 0);
        return free >= 1;
    endfunction

    function automatic bit m_busy();
        return rst && (mq.size() > 0 || m_write);
    endfunction

    function automatic void m_query(output bit h, output logic [15:0] d);
        h = 1'b0;
        d = '0;
        if (!rst) return;
        if (m_write && m_wsel == q_regsel) begin h = 1'b1; d = m_wdata; end
        foreach (mq[i]) if (mq[i].r == q_regsel) begin h = 1'b1; d = mq[i].d; end
    endfunction

    // Advance model and DUT by one rising edge; record observed register-file writes.
    task automatic tick();
        bit   pop, mrdy, ardy;
        ent_t e;
        if (!rst) begin
            mq.delete();
            m_write = 1'b0; m_wsel = '0; m_wdata = '0; m_err = 1'b0;
            last_mh = 1'b0; last_ah = 1'b0;
        end else begin
            pop  = mq.size() > 0;
            mrdy = m_mem_rdy();
            ardy = m_alu_rdy();
            last_mh = mem_valid && mrdy;
            last_ah = alu_valid && ardy;
            m_write = pop;
            if (pop) begin e = mq.pop_front(); m_wsel = e.r; m_wdata = e.d; end
            if (last_mh) mq.push_back({mem_regsel, mem_data});
            if (last_ah) mq.push_back({alu_regsel, alu_data});
            if (last_mh && last_ah && mem_regsel == alu_regsel) m_err = 1'b1;
        end
        @(posedge clk);
        #1;
        if (write === 1'b1) begin
            rf[writeregsel] = writedata;
            wlog.push_back({writeregsel, writedata});
        end
    endtask

    task automatic drain(input string nm);
        int n = 0;
        while ((m_write || mq.size() > 0) && n < 20) begin tick(); n++; end
        n_checks++;
        if (busy !== 1'b0 || n >= 20) $display("FAIL %s_drain busy=%0b cycles=%0d expected busy=0", nm, busy, n);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick();
        tick();
        n_checks++; if (write !== 1'b0) $display("FAIL reset_write got=%0b exp=0", write); else n_pass++;
        n_checks++; if (writeregsel !== 3'd0) $display("FAIL reset_wsel got=%0d exp=0", writeregsel); else n_pass++;
        n_checks++; if (writedata !== 16'h0) $display("FAIL reset_wdata got=%h exp=0", writedata); else n_pass++;
        n_checks++; if (err !== 1'b0) $display("FAIL reset_err got=%0b exp=0", err); else n_pass++;
        alu_valid = 1'b1; mem_valid = 1'b1; q_regsel = 3'd0;
        #1;
        n_checks++; if (alu_ready !== 1'b1 || mem_ready !== 1'b1) $display("FAIL reset_ready alu=%0b mem=%0b exp=1,1", alu_ready, mem_ready); else n_pass++;
        n_checks++; if (busy !== 1'b0 || q_hit !== 1'b0) $display("FAIL reset_busy_qhit busy=%0b q_hit=%0b exp=0,0", busy, q_hit); else n_pass++;
        alu_valid = 1'b0; mem_valid = 1'b0;
        rst = 1'b1;
        #1;
        n_checks++; if (alu_ready !== 1'b1 || mem_ready !== 1'b1) $display("FAIL post_reset_ready alu=%0b mem=%0b exp=1,1", alu_ready, mem_ready); else n_pass++;
        n_checks++; if (busy !== 1'b0 || q_hit !== 1'b0) $display("FAIL post_reset_busy busy=%0b q_hit=%0b exp=0,0", busy, q_hit); else n_pass++;
    endtask

    task automatic test_single();
        alu_valid = 1'b1; alu_regsel = 3'd3; alu_data = 16'h1234;
        #1;
        n_checks++; if (alu_ready !== 1'b1) $display("FAIL single_ready got=%0b exp=1", alu_ready); else n_pass++;
        tick();
        alu_valid = 1'b0;
        n_checks++; if (write !== 1'b0) $display("FAIL single_early got=%0b exp=0", write); else n_pass++;
        tick();
        n_checks++;
        if (write !== 1'b1 || writeregsel !== 3'd3 || writedata !== 16'h1234)
            $display("FAIL single_write got=%0b/%0d/%h exp=1/3/1234", write, writeregsel, writedata);
        else n_pass++;
        tick();
        n_checks++; if (write !== 1'b0 || busy !== 1'b0) $display("FAIL single_idle write=%0b busy=%0b exp=0,0", write, busy); else n_pass++;
    endtask

    task automatic test_order();
        mem_valid = 1'b1; mem_regsel = 3'd1; mem_data = 16'hAAAA;
        alu_valid = 1'b1; alu_regsel = 3'd2; alu_data = 16'h5555;
        tick();
        mem_valid = 1'b0; alu_valid = 1'b0;
        tick();
        n_checks++;
        if (write !== 1'b1 || writeregsel !== 3'd1 || writedata !== 16'hAAAA)
            $display("FAIL order_first got=%0b/%0d/%h exp=1/1/aaaa", write, writeregsel, writedata);
        else n_pass++;
        tick();
        n_checks++;
        if (write !== 1'b1 || writeregsel !== 3'd2 || writedata !== 16'h5555)
            $display("FAIL order_second got=%0b/%0d/%h exp=1/2/5555", write, writeregsel, writedata);
        else n_pass++;
        n_checks++; if (err !== 1'b0) $display("FAIL order_err got=%0b exp=0", err); else n_pass++;
        drain("order");
    endtask

    task automatic test_waw();
        mem_valid = 1'b1; mem_regsel = 3'd4; mem_data = 16'h0001;
        alu_valid = 1'b1; alu_regsel = 3'd4; alu_data = 16'h0002;
        tick();
        mem_valid = 1'b0; alu_valid = 1'b0;
        n_checks++; if (err !== 1'b1) $display("FAIL waw_err_set got=%0b exp=1", err); else n_pass++;
        drain("waw");
        n_checks++; if (err !== 1'b1) $display("FAIL waw_err_sticky got=%0b exp=1", err); else n_pass++;
        n_checks++; if (rf[4] !== 16'h0002) $display("FAIL waw_rf4 got=%h exp=0002", rf[4]); else n_pass++;
    endtask

    task automatic test_backpressure();
        ent_t        expq[$];
        bit          saw_low = 1'b0;
        logic [15:0] seq = 16'h0100;
        wlog.delete();
        mem_valid = 1'b1; mem_regsel = 3'd1; mem_data = seq; seq++;
        alu_valid = 1'b1; alu_regsel = 3'd6; alu_data = seq; seq++;
        for (int c = 0; c < 6; c++) begin
            #1;
            n_checks++; if (mem_ready !== m_mem_rdy()) $display("FAIL bp_mem_ready cyc=%0d got=%0b exp=%0b", c, mem_ready, m_mem_rdy()); else n_pass++;
            n_checks++; if (alu_ready !== m_alu_rdy()) $display("FAIL bp_alu_ready cyc=%0d got=%0b exp=%0b", c, alu_ready, m_alu_rdy()); else n_pass++;
            if (alu_ready === 1'b0) saw_low = 1'b1;
            tick();
            if (last_mh) begin expq.push_back({mem_regsel, mem_data}); mem_data = seq; seq++; end
            if (last_ah) begin expq.push_back({alu_regsel, alu_data}); alu_data = seq; seq++; end
        end
        mem_valid = 1'b0; alu_valid = 1'b0;
        drain("bp");
        n_checks++; if (saw_low !== 1'b1) $display("FAIL bp_ready_drop got=%0b exp=1", saw_low); else n_pass++;
        n_checks++; if (wlog.size() != expq.size()) $display("FAIL bp_count got=%0d exp=%0d", wlog.size(), expq.size()); else n_pass++;
        for (int i = 0; i < expq.size(); i++) begin
            n_checks++;
            if (i >= wlog.size() || wlog[i] !== expq[i])
                $display("FAIL bp_seq idx=%0d got=%h exp=%h", i, (i < wlog.size()) ? wlog[i] : ent_t'(0), expq[i]);
            else n_pass++;
        end
    endtask

    task automatic test_query();
        alu_valid = 1'b1; alu_regsel = 3'd5; alu_data = 16'h0010;
        tick();
        alu_data = 16'h0020;
        tick();
        alu_valid = 1'b0; q_regsel = 3'd5;
        #1;
        n_checks++; if (q_hit !== 1'b1) $display("FAIL query_hit got=%0b exp=1", q_hit); else n_pass++;
        n_checks++; if (q_data !== 16'h0020) $display("FAIL query_data got=%h exp=0020", q_data); else n_pass++;
        drain("query");
        #1;
        n_checks++; if (q_hit !== 1'b0 || q_data !== 16'h0) $display("FAIL query_empty got=%0b/%h exp=0/0000", q_hit, q_data); else n_pass++;
    endtask

    task automatic test_reset_flush();
        mem_valid = 1'b1; mem_regsel = 3'd1; mem_data = 16'h0A01;
        alu_valid = 1'b1; alu_regsel = 3'd2; alu_data = 16'h0A02;
        tick();
        mem_regsel = 3'd3; mem_data = 16'h0A03;
        alu_regsel = 3'd6; alu_data = 16'h0A04;
        tick();
        mem_valid = 1'b0; alu_valid = 1'b0;
        n_checks++; if (mq.size() != 3 || err !== 1'b1) $display("FAIL flush_setup queued=%0d err=%0b exp=3,1", mq.size(), err); else n_pass++;
        rst = 1'b0;
        tick();
        n_checks++;
        if (write !== 1'b0 || busy !== 1'b0 || err !== 1'b0)
            $display("FAIL flush_state write=%0b busy=%0b err=%0b exp=0,0,0", write, busy, err);
        else n_pass++;
        rst = 1'b1;
        wlog.delete();
        for (int i = 0; i < 4; i++) tick();
        n_checks++; if (wlog.size() != 0) $display("FAIL flush_no_write got=%0d writes exp=0", wlog.size()); else n_pass++;
    endtask

    task automatic test_random();
        bit          eh;
        logic [15:0] ed;
        for (int c = 0; c < 300; c++) begin
            if (!(alu_valid && !last_ah)) begin
                alu_valid  = ($urandom_range(0, 3) != 0);
                alu_regsel = 3'($urandom);
                alu_data   = 16'($urandom);
            end
            if (!(mem_valid && !last_mh)) begin
                mem_valid  = ($urandom_range(0, 3) != 0);
                mem_regsel = 3'($urandom);
                mem_data   = 16'($urandom);
            end
            q_regsel = 3'($urandom);
            #1;
            m_query(eh, ed);
            n_checks++; if (mem_ready !== m_mem_rdy()) $display("FAIL rnd_mem_ready cyc=%0d got=%0b exp=%0b", c, mem_ready, m_mem_rdy()); else n_pass++;
            n_checks++; if (alu_ready !== m_alu_rdy()) $display("FAIL rnd_alu_ready cyc=%0d got=%0b exp=%0b", c, alu_ready, m_alu_rdy()); else n_pass++;
            n_checks++; if (busy !== m_busy()) $display("FAIL rnd_busy cyc=%0d got=%0b exp=%0b", c, busy, m_busy()); else n_pass++;
            n_checks++; if (q_hit !== eh || q_data !== ed) $display("FAIL rnd_query cyc=%0d got=%0b/%h exp=%0b/%h", c, q_hit, q_data, eh, ed); else n_pass++;
            tick();
            n_checks++; if (write !== m_write) $display("FAIL rnd_write cyc=%0d got=%0b exp=%0b", c, write, m_write); else n_pass++;
            if (m_write) begin
                n_checks++;
                if (writeregsel !== m_wsel || writedata !== m_wdata)
                    $display("FAIL rnd_wdata cyc=%0d got=%0d/%h exp=%0d/%h", c, writeregsel, writedata, m_wsel, m_wdata);
                else n_pass++;
            end
            n_checks++; if (err !== m_err) $display("FAIL rnd_err cyc=%0d got=%0b exp=%0b", c, err, m_err); else n_pass++;
        end
        alu_valid = 1'b0; mem_valid = 1'b0;
        drain("rnd");
    endtask

    initial begin
        rst = 1'b0;
        alu_valid = 1'b0; alu_regsel = '0; alu_data = '0;
        mem_valid = 1'b0; mem_regsel = '0; mem_data = '0;
        q_regsel = '0;
        m_write = 1'b0; m_wsel = '0; m_wdata = '0; m_err = 1'b0;
        last_mh = 1'b0; last_ah = 1'b0;
        for (int i = 0; i < 8; i++) rf[i] = '0;
        test_reset();
        test_single();
        test_order();
        test_waw();
        test_backpressure();
        test_query();
        test_reset_flush();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
